fir_ntap_sum_pipe: RTL and testbench

//  Parametrised successor to the fixed 4-tap signed summing FIR.
//  - Sums the last TAPS accepted W-bit two's-complement samples.
//  - Pipelined adder tree with valid qualification and fill tracking.
//  - Synchronous clear.
//  - Drop-in datapath block for the filter projects: feeds averaging and decimation stages.

---
 rtl/fir_ntap_sum_pipe_pkg.sv | 13 +
 rtl/fir_ntap_sum_pipe_if.sv | 25 ++
 rtl/fir_ntap_sum_pipe_add_stage.sv | 39 +++
 rtl/fir_ntap_sum_pipe.sv | 92 +++++++++
 tb/tb_fir_ntap_sum_pipe.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/fir_ntap_sum_pipe_pkg.sv
// Shared definitions for the N-tap summing FIR: tap limit, fill-counter type
// and the elaboration helper used to validate the TAPS parameter.
package fir_pkg;

  localparam int MAX_TAPS = 16;

  typedef logic [$clog2(MAX_TAPS):0] fir_cnt_t;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fir_ntap_sum_pipe_if.sv
// Sample/sum bus of the N-tap summing FIR. The avg signal exists only when
// FIR_AVG_OUT_EN is defined.
interface fir_ntap_sum_pipe_if #(
  parameter int W    = 16,
  parameter int TAPS = 4
);
  localparam int L = $clog2(TAPS);

  logic                  clr;
  logic                  in_valid;
  logic signed [W-1:0]   a;
  logic                  out_valid;
  logic signed [W+L-1:0] s;
  logic                  primed;
`ifdef FIR_AVG_OUT_EN
  logic signed [W-1:0]   avg;

  modport master (output clr, in_valid, a, input out_valid, s, primed, avg);
  modport slave  (input clr, in_valid, a, output out_valid, s, primed, avg);
`else
  modport master (output clr, in_valid, a, input out_valid, s, primed);
  modport slave  (input clr, in_valid, a, output out_valid, s, primed);
`endif

endinterface

// File: rtl/fir_ntap_sum_pipe_add_stage.sv
// One registered adder-tree level: N signed IW-bit operands in, N/2 signed
// (IW+1)-bit pairwise sums out, with a valid bit travelling alongside.
module fir_add_stage #(
  parameter int IW   = 16,
  parameter int N    = 4,
  parameter bit HOLD = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic [N*IW-1:0]           d,
  input  logic                      in_v,
  output logic [(N/2)*(IW+1)-1:0]   q,
  output logic                      out_v
);

  logic [(N/2)*(IW+1)-1:0] sum;

  // Each operand is sign-extended by one bit first, so the add cannot overflow.
  for (genvar i = 0; i < N / 2; i++) begin : g_pair
    logic [IW-1:0] x;
    logic [IW-1:0] y;
    assign x = d[(2*i)*IW +: IW];
    assign y = d[(2*i+1)*IW +: IW];
    assign sum[i*(IW+1) +: IW+1] = {x[IW-1], x} + {y[IW-1], y};
  end

  // The final level only loads on a valid window so the sum holds between pulses.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q     <= '0;
      out_v <= 1'b0;
    end else begin
      out_v <= in_v;
      if (!HOLD || in_v) q <= sum;
    end
  end

endmodule

// File: rtl/fir_ntap_sum_pipe.sv
// Sums the last TAPS accepted signed samples through an L-level pipelined tree.
// Optional window average output enabled by defining FIR_AVG_OUT_EN.
module fir_ntap_sum_pipe
  import fir_pkg::*;
#(
  parameter int W    = 16,
  parameter int TAPS = 4
) (
  input logic               clk,
  input logic               reset,
  fir_ntap_sum_pipe_if.slave bus
);

  localparam int       L    = $clog2(TAPS);
  localparam fir_cnt_t FULL = fir_cnt_t'(TAPS);

  if (!is_pow2(TAPS) || TAPS < 2 || TAPS > MAX_TAPS) begin : g_bad_taps
    $fatal(1, "fir_ntap_sum_pipe: TAPS must be a power of two in 2..16");
  end
  if (W < 2 || W > 32) begin : g_bad_w
    $fatal(1, "fir_ntap_sum_pipe: W must be in 2..32");
  end

  // Delay line packed with tap[0] in the low W bits.
  logic [TAPS*W-1:0] line;
  fir_cnt_t          cnt;
  fir_cnt_t          cnt_nxt;
  logic              win_v;
  logic              primed;

  assign cnt_nxt = (cnt == FULL) ? cnt : cnt + fir_cnt_t'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make tap[i] see the new tap[i-1].
  always_ff @(posedge clk) begin
    if (reset || bus.clr) begin
      line   <= '0;
      cnt    <= '0;
      primed <= 1'b0;
      win_v  <= 1'b0;
    end else begin
      win_v <= 1'b0;
      if (bus.in_valid) begin
        line   <= {line[(TAPS-1)*W-1:0], bus.a};
        cnt    <= cnt_nxt;
        primed <= (cnt_nxt == FULL);
        win_v  <= (cnt_nxt == FULL);
      end
    end
  end

  assign bus.primed = primed;

  for (genvar j = 0; j < L; j++) begin : g_lvl
    localparam int IW = W + j;
    localparam int N  = TAPS >> j;

    logic [(N/2)*(IW+1)-1:0] q;
    logic                    v;

    if (j == 0) begin : g_in
      fir_add_stage #(.IW(IW), .N(N), .HOLD(j == L - 1)) u_stage (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clr),
        .d     (line),
        .in_v  (win_v),
        .q     (q),
        .out_v (v)
      );
    end else begin : g_in
      fir_add_stage #(.IW(IW), .N(N), .HOLD(j == L - 1)) u_stage (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clr),
        .d     (g_lvl[j-1].q),
        .in_v  (g_lvl[j-1].v),
        .q     (q),
        .out_v (v)
      );
    end
  end

  assign bus.s         = g_lvl[L-1].q;
  assign bus.out_valid = g_lvl[L-1].v;

`ifdef FIR_AVG_OUT_EN
  // Arithmetic shift by L realised as a slice: floor division by TAPS.
  assign bus.avg = bus.s[W+L-1:L];
`endif

endmodule

// File: tb/tb_fir_ntap_sum_pipe.sv
// Self-checking bench for fir_ntap_sum_pipe: directed cases plus randomized
// traffic compared every cycle against a queue-based window-sum model.
module tb_fir_ntap_sum_pipe;

  localparam int W    = 16;
  localparam int TAPS = 4;
  localparam int L    = $clog2(TAPS);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir_ntap_sum_pipe_if #(.W(W), .TAPS(TAPS)) bus ();

  fir_ntap_sum_pipe #(.W(W), .TAPS(TAPS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit     v;
    longint sum;
  } ent_t;

  longint win[$];
  ent_t   pipe[$];
  int     cnt;
  longint exp_s;
  bit     exp_ov;
  bit     exp_primed;
  string  phase = "init";

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s.%s: got %0d expected %0d", phase, tag, got, exp);
  endtask

  // Model: window = last TAPS accepted samples; each full window yields a sum
  // that appears L edges later. reset/clr wipe the window and all in-flight sums.
  task automatic model_step(input bit r, input bit c, input bit v, input longint a);
    ent_t   e;
    longint t;
    if (r || c) begin
      win.delete();
      pipe.delete();
      for (int i = 0; i < L; i++) pipe.push_back('{1'b0, 0});
      cnt        = 0;
      exp_s      = 0;
      exp_ov     = 1'b0;
      exp_primed = 1'b0;
    end else begin
      e = '{1'b0, 0};
      if (v) begin
        win.push_front(a);
        if (win.size() > TAPS) void'(win.pop_back());
        if (cnt < TAPS) cnt++;
        if (cnt == TAPS) begin
          t = 0;
          foreach (win[i]) t += win[i];
          e = '{1'b1, t};
        end
        exp_primed = (cnt == TAPS);
      end
      pipe.push_back(e);
      e      = pipe.pop_front();
      exp_ov = e.v;
      if (e.v) exp_s = e.sum;
    end
  endtask

  task automatic cycle(input bit r, input bit c, input bit v, input logic [W-1:0] a);
    reset        = r;
    bus.clr      = c;
    bus.in_valid = v;
    bus.a        = a;
    @(posedge clk);
    model_step(r, c, v, longint'($signed(a)));
    #1;
    check("out_valid", longint'(bus.out_valid), longint'(exp_ov));
    check("s", longint'($signed(bus.s)), exp_s);
    check("primed", longint'(bus.primed), longint'(exp_primed));
`ifdef FIR_AVG_OUT_EN
    check("avg", longint'($signed(bus.avg)), exp_s >>> L);
`endif
  endtask

  task automatic feed(input logic [W-1:0] a);
    cycle(1'b0, 1'b0, 1'b1, a);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, '0);
  endtask

  logic [W-1:0] ra;
  bit           rr, rc, rv;

  initial begin
    reset        = 1'b1;
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;

    phase = "t1";
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("rst_s", longint'($signed(bus.s)), 0);
    check("rst_primed", longint'(bus.primed), 0);
    feed(16'd1); feed(16'd2); feed(16'd3); feed(16'd4);
    check("primed_after_4", longint'(bus.primed), 1);
    idle();
    check("ov_early", longint'(bus.out_valid), 0);
    idle();
    check("ov_lat", longint'(bus.out_valid), 1);
    check("sum10", longint'($signed(bus.s)), 10);

    phase = "t2";
    repeat (4) feed(16'h8000);
    idle(); idle();
    check("min_sum", longint'($signed(bus.s)), -131072);
    repeat (4) feed(16'h7FFF);
    idle(); idle();
    check("max_sum", longint'($signed(bus.s)), 131068);

    phase = "t3";
    cycle(1'b1, 1'b0, 1'b0, '0);
    feed(16'd5);
    idle(); idle(); idle();
    feed(16'd6); feed(16'd7); feed(16'd8);
    idle(); idle();
    check("gap_ov", longint'(bus.out_valid), 1);
    check("gap_sum", longint'($signed(bus.s)), 26);
    idle();
    check("gap_hold_ov", longint'(bus.out_valid), 0);
    check("gap_hold_s", longint'($signed(bus.s)), 26);

    phase = "t4";
    feed(16'd1); feed(16'd2); feed(16'd3); feed(16'd4); feed(16'd5);
    cycle(1'b0, 1'b1, 1'b1, 16'd100);
    check("clr_primed", longint'(bus.primed), 0);
    check("clr_ov", longint'(bus.out_valid), 0);
    for (int i = 0; i < L + 1; i++) begin
      idle();
      check("clr_flush_ov", longint'(bus.out_valid), 0);
    end
    feed(16'd10); feed(16'd20); feed(16'd30);
    check("clr_not_primed", longint'(bus.primed), 0);
    feed(16'd40);
    idle(); idle();
    check("clr_refill_ov", longint'(bus.out_valid), 1);
    check("clr_refill_s", longint'($signed(bus.s)), 100);

    phase = "t5";
    for (int i = 0; i < 6; i++) feed(W'(i * 3 + 1));
    cycle(1'b1, 1'b0, 1'b1, 16'd55);
    check("mid_rst_s", longint'($signed(bus.s)), 0);
    check("mid_rst_ov", longint'(bus.out_valid), 0);
    check("mid_rst_primed", longint'(bus.primed), 0);

    phase = "t6";
    feed(16'hFFFF); feed(16'hFFFF); feed(16'hFFFF); feed(16'hFFFE);
    idle(); idle();
    check("neg_sum", longint'($signed(bus.s)), -5);
`ifdef FIR_AVG_OUT_EN
    check("neg_avg", longint'($signed(bus.avg)), -2);
`endif

    phase = "rand";
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 99) == 0);
      rc = ($urandom_range(0, 49) == 0);
      rv = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       ra = {1'b1, {(W-1){1'b0}}};
        1:       ra = {1'b0, {(W-1){1'b1}}};
        2:       ra = '1;
        default: ra = W'($urandom);
      endcase
      cycle(rr, rc, rv, ra);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
